dct2_row_sched: RTL

- Row scheduler for the 1D DCT-II engine: butterfly stages plus the output permutation register.
- Accepts a stream of input row vectors, latches the transform size per block and strobes the datapath once per admitted row.
- Tracks rows in flight through a fixed-latency pipeline and raises output valid/last aligned with the permuted 512-bit result.
- The datapath cannot stall, so backpressure uses credits against the downstream result FIFO.

---
 rtl/dct2_row_sched_pkg.sv | 31 +++
 rtl/dct2_row_sched_if.sv | 35 +++
 rtl/dct2_row_sched_tag_pipe.sv | 43 ++++
 rtl/dct2_row_sched.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/dct2_row_sched_pkg.sv
// dct2_pkg: shared types for the DCT-II row scheduler.
//   size_t   - transform size code (SZ4, SZ8, SZ16, SZ32)
//   state_t  - scheduler FSM state (IDLE, RUN, DRAIN)
//   tag_t    - per-row tag {valid, last, size} carried through the pipeline
//   size_to_points - size code to number of transform points
package dct2_pkg;

    typedef enum logic [1:0] {
        SZ4  = 2'd0,
        SZ8  = 2'd1,
        SZ16 = 2'd2,
        SZ32 = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic  valid;
        logic  last;
        size_t size;
    } tag_t;

    function automatic logic [5:0] size_to_points(input size_t sz);
        return 6'd4 << sz;
    endfunction

endpackage

// File: rtl/dct2_row_sched_if.sv
// dct2_row_sched_if: input row stream, datapath strobe, result stream and
// status of the DCT-II row scheduler.
//   slave  - scheduler side (dct2_row_sched)
//   master - source / downstream side (row producer, result FIFO)
// Parameter ROWS_W must match the scheduler instance.
interface dct2_row_sched_if #(
    parameter int unsigned ROWS_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sop;
    logic [1:0]        in_size;
    logic [ROWS_W-1:0] in_rows;
    logic              dp_en;
    logic [1:0]        dp_n;
    logic              out_valid;
    logic              out_last;
    logic [1:0]        out_size;
    logic              fifo_pop;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  in_valid, in_sop, in_size, in_rows, fifo_pop,
        output in_ready, dp_en, dp_n, out_valid, out_last, out_size,
               busy, done, err
    );

    modport master (
        output in_valid, in_sop, in_size, in_rows, fifo_pop,
        input  in_ready, dp_en, dp_n, out_valid, out_last, out_size,
               busy, done, err
    );
endinterface

// File: rtl/dct2_row_sched_tag_pipe.sv
// dct2_tag_pipe: DEPTH-stage shift register of row tags {valid, last, size}
// tracking rows in flight through the fixed-latency datapath.
//   clk, rst_n - clock, synchronous active-low clear
//   in_tag     - tag loaded into stage 0 every cycle
//   out_tag    - tag of the last stage
//   any_valid  - some stage holds a valid row
module dct2_tag_pipe
    import dct2_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t in_tag,
    output tag_t out_tag,
    output logic any_valid
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_tag = stage[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

endmodule

// File: rtl/dct2_row_sched.sv
// dct2_row_sched: row scheduler for the 1D DCT-II engine.
// Admits input rows against credits for the downstream result FIFO, strobes
// the datapath once per admitted row, and tracks rows in flight so that
// out_valid/out_last/out_size line up with the permuted result PIPE_LAT
// cycles after dp_en.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - dct2_row_sched_if.slave: in_* row stream, dp_en/dp_n
//                datapath control, out_* result tags, fifo_pop credit
//                return, busy/done/err status
// Optional (macro DCT2_ROW_SCHED_PERF_EN):
//   stall_cnt  - saturating count of cycles with in_valid & !in_ready
//   blk_cnt    - wrapping count of completed blocks
module dct2_row_sched
    import dct2_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned CREDITS  = 4,
    parameter int unsigned ROWS_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    dct2_row_sched_if.slave     bus
`ifdef DCT2_ROW_SCHED_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [15:0]         blk_cnt
`endif
);

    localparam int unsigned     CW       = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS);

    state_t            state;
    logic [CW-1:0]     credits;
    logic [ROWS_W-1:0] cnt;
    logic [ROWS_W-1:0] rows_q;
    size_t             size_q;
    logic              err_q;

    logic   in_ready;
    logic   admit;
    logic   sop_take;
    logic   discard;
    logic   take;
    logic   final_row;
    logic   pop_ok;
    logic   pop_bad;
    logic   blk_end;
    size_t  cur_size;
    tag_t   in_tag;
    tag_t   out_tag;
    logic   pipe_busy;

    always_comb begin
        in_ready  = ((state == IDLE) || (state == RUN)) && (credits != '0);
        admit     = bus.in_valid & in_ready;
        sop_take  = admit & (state == IDLE) & bus.in_sop;
        // A non-sop beat in IDLE is consumed but never reaches the datapath.
        discard   = admit & (state == IDLE) & ~bus.in_sop;
        take      = admit & ~discard;
        final_row = (state == IDLE) ? (bus.in_rows == '0)
                                    : (cnt == (rows_q - ROWS_W'(1)));
        // The sop row itself must already see its own size on dp_n.
        cur_size  = sop_take ? size_t'(bus.in_size) : size_q;
        pop_ok    = bus.fifo_pop & (credits != CRED_MAX);
        pop_bad   = bus.fifo_pop & (credits == CRED_MAX);
        blk_end   = (state == DRAIN) & out_tag.valid & out_tag.last;

        in_tag.valid = take;
        in_tag.last  = take & final_row;
        in_tag.size  = take ? cur_size : SZ4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            credits <= CRED_MAX;
            cnt     <= '0;
            rows_q  <= '0;
            size_q  <= SZ4;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sop_take) begin
                        size_q <= size_t'(bus.in_size);
                        rows_q <= bus.in_rows;
                        cnt    <= '0;
                        state  <= (bus.in_rows == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (take) begin
                        cnt <= cnt + ROWS_W'(1);
                        if (final_row) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (blk_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (take && !pop_ok) begin
                credits <= credits - CW'(1);
            end else if (!take && pop_ok) begin
                credits <= credits + CW'(1);
            end

            if (discard || pop_bad || (admit && (state == RUN) && bus.in_sop)) begin
                err_q <= 1'b1;
            end
        end
    end

    dct2_tag_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_tag    (in_tag),
        .out_tag   (out_tag),
        .any_valid (pipe_busy)
    );

    assign bus.in_ready  = in_ready;
    assign bus.dp_en     = take;
    assign bus.dp_n      = cur_size;
    assign bus.out_valid = out_tag.valid;
    assign bus.out_last  = out_tag.last;
    assign bus.out_size  = out_tag.size;
    assign bus.busy      = (state != IDLE) | pipe_busy;
    assign bus.done      = blk_end;
    assign bus.err       = err_q;

`ifdef DCT2_ROW_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            blk_cnt   <= '0;
        end else begin
            if (bus.in_valid && !in_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (blk_end) begin
                blk_cnt <= blk_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
